// File: rtl/npc_halt_pkg.sv
// Shared constants and types for the NPC simulation halt controller.
package npc_halt_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EBREAK  = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_ILLEGAL = 2'd3
    } halt_cause_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } halt_state_t;

endpackage

// File: rtl/npc_watchdog.sv
// Forward-progress watchdog: counts consecutive enabled cycles without a kick.
module npc_watchdog
    import npc_halt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic expire
);

    localparam int unsigned IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] LIMIT = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [IW-1:0] idle_q;
    logic [IW-1:0] idle_d;

    // A kick on the threshold cycle wins over expiry, so the compare is gated by !kick.
    always_comb begin
        idle_d = idle_q;
        if (!en || kick || !ENABLED) begin
            idle_d = '0;
        end else if (idle_q != LIMIT) begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign expire = ENABLED && en && !kick && (idle_q == LIMIT);

endmodule

// File: rtl/npc_halt_ctrl.sv
// Halt controller: detects EBREAK / illegal / timeout, drains the pipeline,
// then freezes cause, PC, exit code and run counters for the testbench.
module npc_halt_ctrl
    import npc_halt_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned COUNT_W        = 64
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               retire_valid,
    input  logic [31:0]        retire_inst,
    input  logic [31:0]        retire_pc,
    input  logic               retire_illegal,
    input  logic [31:0]        gpr_a0,
    output logic               halt_req,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [31:0]        halt_pc,
    output logic [31:0]        exit_code,
    output logic               good_trap,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [COUNT_W-1:0] inst_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    halt_state_t        state_q;
    halt_cause_t        cause_q;
    logic [DW-1:0]      drainCnt_q;
    logic [31:0]        haltPc_q;
    logic [31:0]        exitCode_q;
    logic [31:0]        lastPc_q;
    logic               haltReq_q;
    logic               halted_q;
    logic               goodTrap_q;
    logic [COUNT_W-1:0] cycleCnt_q;
    logic [COUNT_W-1:0] instCnt_q;
    logic [COUNT_W-1:0] cycleCnt_d;
    logic [COUNT_W-1:0] instCnt_d;
    logic               expire;

    npc_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock (clock),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .kick  (retire_valid),
        .expire(expire)
    );

    // Saturating increments so long runs pin at all-ones instead of wrapping.
    always_comb begin
        cycleCnt_d = (cycleCnt_q == '1) ? cycleCnt_q : cycleCnt_q + COUNT_W'(1);
        instCnt_d  = (instCnt_q  == '1) ? instCnt_q  : instCnt_q  + COUNT_W'(1);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cause_q    <= CAUSE_NONE;
            drainCnt_q <= '0;
            haltPc_q   <= '0;
            exitCode_q <= '0;
            lastPc_q   <= '0;
            haltReq_q  <= 1'b0;
            halted_q   <= 1'b0;
            goodTrap_q <= 1'b0;
            cycleCnt_q <= '0;
            instCnt_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    cycleCnt_q <= cycleCnt_d;
                    if (retire_valid) begin
                        instCnt_q <= instCnt_d;
                        lastPc_q  <= retire_pc;
                        if (retire_illegal) begin
                            cause_q    <= CAUSE_ILLEGAL;
                            haltPc_q   <= retire_pc;
                            exitCode_q <= '1;
                            haltReq_q  <= 1'b1;
                            drainCnt_q <= DRAIN_LOAD;
                            state_q    <= DRAIN;
                        end else if (retire_inst == EBREAK_INST) begin
                            cause_q    <= CAUSE_EBREAK;
                            haltPc_q   <= retire_pc;
                            exitCode_q <= gpr_a0;
                            haltReq_q  <= 1'b1;
                            drainCnt_q <= DRAIN_LOAD;
                            state_q    <= DRAIN;
                        end
                    end else if (expire) begin
                        // Nothing is in flight after a stall, so skip the drain.
                        cause_q    <= CAUSE_TIMEOUT;
                        haltPc_q   <= lastPc_q;
                        exitCode_q <= '1;
                        haltReq_q  <= 1'b1;
                        halted_q   <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DRAIN: begin
                    cycleCnt_q <= cycleCnt_d;
                    if (drainCnt_q == '0) begin
                        halted_q   <= 1'b1;
                        goodTrap_q <= (cause_q == CAUSE_EBREAK) && (exitCode_q == 32'd0);
                        state_q    <= DONE;
                    end else begin
                        drainCnt_q <= drainCnt_q - DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign halt_req    = haltReq_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign halt_pc     = haltPc_q;
    assign exit_code   = exitCode_q;
    assign good_trap   = goodTrap_q;
    assign cycle_count = cycleCnt_q;
    assign inst_count  = instCnt_q;

endmodule

// File: tb/tb_npc_halt_ctrl.sv
// Self-checking bench for npc_halt_ctrl: directed scenarios plus random retire
// streams compared against an event-level reference model.
module tb_npc_halt_ctrl;
    import npc_halt_pkg::*;

    localparam int DRAIN = 4;
    localparam int TMO   = 8;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        retireValid;
    logic [31:0] retireInst;
    logic [31:0] retirePc;
    logic        retireIllegal;
    logic [31:0] gprA0;

    logic        haltReqA, haltedA, goodTrapA;
    logic [1:0]  haltCauseA;
    logic [31:0] haltPcA, exitCodeA;
    logic [63:0] cycleCountA, instCountA;

    logic        haltReqB, haltedB, goodTrapB;
    logic [1:0]  haltCauseB;
    logic [31:0] haltPcB, exitCodeB;
    logic [3:0]  cycleCountB, instCountB;

    int vectors = 0;
    int errors  = 0;

    bit              mStopped, mFinished;
    int              mDrainLeft, mIdle, mCause;
    longint unsigned mCycles, mInsts;
    logic [31:0]     mLastPc, mPc, mExit;

    always #5 clock = ~clock;

    npc_halt_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO), .COUNT_W(64)) dutWide (
        .clock(clock), .rst_n(rst_n), .retire_valid(retireValid), .retire_inst(retireInst),
        .retire_pc(retirePc), .retire_illegal(retireIllegal), .gpr_a0(gprA0),
        .halt_req(haltReqA), .halted(haltedA), .halt_cause(haltCauseA), .halt_pc(haltPcA),
        .exit_code(exitCodeA), .good_trap(goodTrapA), .cycle_count(cycleCountA),
        .inst_count(instCountA));

    npc_halt_ctrl #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO), .COUNT_W(4)) dutNarrow (
        .clock(clock), .rst_n(rst_n), .retire_valid(retireValid), .retire_inst(retireInst),
        .retire_pc(retirePc), .retire_illegal(retireIllegal), .gpr_a0(gprA0),
        .halt_req(haltReqB), .halted(haltedB), .halt_cause(haltCauseB), .halt_pc(haltPcB),
        .exit_code(exitCodeB), .good_trap(goodTrapB), .cycle_count(cycleCountB),
        .inst_count(instCountB));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [63:0] satW(input longint unsigned v, input int w);
        longint unsigned lim;
        if (w >= 64) return v;
        lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic modelReset();
        mStopped = 0; mFinished = 0; mDrainLeft = 0; mIdle = 0; mCause = 0;
        mCycles = 0; mInsts = 0; mLastPc = '0; mPc = '0; mExit = '0;
    endtask

    // One clock edge of the reference: a run ends on a trap (then DRAIN edges
    // of draining) or after TMO consecutive retire-free edges.
    task automatic modelStep(input bit rv, input logic [31:0] inst, input logic [31:0] pc,
                             input bit ill, input logic [31:0] a0);
        if (mFinished) return;
        mCycles++;
        if (mStopped) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mFinished = 1;
        end else if (rv) begin
            mInsts++;
            mLastPc = pc;
            mIdle = 0;
            if (ill || inst == EBREAK_INST) begin
                mCause = ill ? 3 : 1;
                mPc = pc;
                mExit = ill ? 32'hFFFF_FFFF : a0;
                mStopped = 1;
                mDrainLeft = DRAIN;
            end
        end else begin
            mIdle++;
            if (mIdle == TMO) begin
                mCause = 2; mPc = mLastPc; mExit = 32'hFFFF_FFFF;
                mStopped = 1; mFinished = 1;
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".halt_req"},  64'(haltReqA),   64'(mStopped));
        checkOutput({tag, ".halted"},    64'(haltedA),    64'(mFinished));
        checkOutput({tag, ".cause"},     64'(haltCauseA), 64'(mCause));
        checkOutput({tag, ".halt_pc"},   64'(haltPcA),    64'(mPc));
        checkOutput({tag, ".exit_code"}, 64'(exitCodeA),  64'(mExit));
        checkOutput({tag, ".cycles"},    cycleCountA,     satW(mCycles, 64));
        checkOutput({tag, ".insts"},     instCountA,      satW(mInsts, 64));
        checkOutput({tag, ".cycles4"},   64'(cycleCountB), satW(mCycles, 4));
        checkOutput({tag, ".insts4"},    64'(instCountB),  satW(mInsts, 4));
        checkOutput({tag, ".halted4"},   64'(haltedB),     64'(mFinished));
        if (mFinished)
            checkOutput({tag, ".good_trap"}, 64'(goodTrapA),
                        64'(mCause == 1 && mExit == 32'd0));
    endtask

    task automatic applyStimulus(input bit rv, input logic [31:0] inst, input logic [31:0] pc,
                                 input bit ill, input logic [31:0] a0, input string tag);
        retireValid = rv; retireInst = inst; retirePc = pc; retireIllegal = ill; gprA0 = a0;
        @(posedge clock);
        modelStep(rv, inst, pc, ill, a0);
        #1;
        compareAll(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 32'h0, 0, 32'h0, tag);
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is visible before any edge.
    task automatic applyReset(input string tag);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll(tag);
        retireValid = 0; retireInst = '0; retirePc = '0; retireIllegal = 0; gprA0 = '0;
        @(posedge clock);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        retireValid = 0; retireInst = '0; retirePc = '0; retireIllegal = 0; gprA0 = '0;
        applyReset("reset");

        // Good trap: five nops, EBREAK with a0=0, halted exactly DRAIN edges later.
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 32'h0000_0013, 32'h8000_0000 + 32'(4 * i), 0, 32'h5, "gt_nop");
        applyStimulus(1, EBREAK_INST, 32'h8000_0014, 0, 32'h0, "gt_trap");
        idleCycles(3, "gt_drain");
        checkOutput("gt_notyet", 64'(haltedA), 64'd0);
        idleCycles(1, "gt_drain");
        checkOutput("gt_halted", 64'(haltedA), 64'd1);
        checkOutput("gt_cause", 64'(haltCauseA), 64'd1);
        checkOutput("gt_good", 64'(goodTrapA), 64'd1);
        checkOutput("gt_insts", instCountA, 64'd6);
        checkOutput("gt_pc", 64'(haltPcA), 64'h8000_0014);
        applyStimulus(1, EBREAK_INST, 32'h1234, 1, 32'h7, "gt_frozen");

        // Bad trap with a retire slipping in during drain.
        applyReset("bt_reset");
        applyStimulus(1, 32'h0000_0013, 32'h100, 0, 32'h0, "bt_nop");
        applyStimulus(1, EBREAK_INST, 32'h104, 0, 32'h2A, "bt_trap");
        applyStimulus(1, 32'h0000_0013, 32'h108, 0, 32'h0, "bt_drainret");
        checkOutput("bt_insts", instCountA, 64'd2);
        idleCycles(3, "bt_drain");
        checkOutput("bt_exit", 64'(exitCodeA), 64'h2A);
        checkOutput("bt_good", 64'(goodTrapA), 64'd0);
        checkOutput("bt_cause", 64'(haltCauseA), 64'd1);

        // Illegal flag beats EBREAK decode.
        applyReset("il_reset");
        applyStimulus(1, EBREAK_INST, 32'h200, 1, 32'h0, "il_trap");
        idleCycles(DRAIN, "il_drain");
        checkOutput("il_cause", 64'(haltCauseA), 64'd3);
        checkOutput("il_exit", 64'(exitCodeA), 64'hFFFF_FFFF);

        // Watchdog expiry with no retires at all.
        applyReset("wd_reset");
        idleCycles(TMO - 1, "wd_idle");
        checkOutput("wd_notyet", 64'(haltedA), 64'd0);
        idleCycles(1, "wd_idle");
        checkOutput("wd_halted", 64'(haltedA), 64'd1);
        checkOutput("wd_req", 64'(haltReqA), 64'd1);
        checkOutput("wd_cause", 64'(haltCauseA), 64'd2);
        checkOutput("wd_pc", 64'(haltPcA), 64'd0);

        // Retire on the threshold cycle suppresses the timeout.
        applyReset("wk_reset");
        idleCycles(TMO - 1, "wk_idle");
        applyStimulus(1, 32'h0000_0013, 32'h300, 0, 32'h0, "wk_kick");
        idleCycles(3, "wk_after");
        checkOutput("wk_nohalt", 64'(haltedA), 64'd0);

        // Reset while draining, then a clean run.
        applyReset("rd_reset");
        applyStimulus(1, EBREAK_INST, 32'h400, 0, 32'h1, "rd_trap");
        idleCycles(2, "rd_drain");
        applyReset("rd_abort");
        checkOutput("rd_req0", 64'(haltReqA), 64'd0);
        applyStimulus(1, EBREAK_INST, 32'h500, 0, 32'h0, "rd_trap2");
        idleCycles(DRAIN, "rd_drain2");
        checkOutput("rd_halted", 64'(haltedA), 64'd1);

        // Narrow counters saturate at 15.
        applyReset("sat_reset");
        for (int i = 0; i < 20; i++)
            applyStimulus(1, 32'h0000_0013, 32'(i * 4), 0, 32'h0, "sat_ret");
        checkOutput("sat_insts4", 64'(instCountB), 64'd15);
        checkOutput("sat_insts", instCountA, 64'd20);

        // Random retire streams.
        for (int ep = 0; ep < 10; ep++) begin
            int pRet;
            int tail;
            applyReset("rnd_reset");
            pRet = $urandom_range(35, 95);
            tail = 0;
            for (int c = 0; c < 120 && tail < 3; c++) begin
                bit          rv, ill;
                logic [31:0] inst, a0;
                rv   = ($urandom_range(0, 99) < pRet);
                ill  = ($urandom_range(0, 39) == 0);
                inst = $urandom;
                if (inst == EBREAK_INST) inst = 32'h0000_0013;
                if ($urandom_range(0, 24) == 0) inst = EBREAK_INST;
                a0   = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
                applyStimulus(rv, inst, $urandom, ill, a0, "rnd");
                if (mFinished) tail++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
